// File: rtl/uart_fifo_bridge.sv
// Buffered bus front-end for the UART core: a TX FIFO drained one byte at a time
// into the core, an RX FIFO filled from the core, and DATA / STATUS-CTRL registers.
module uart_fifo_bridge #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rw,
  input  logic        writeenable,
  input  logic [31:0] writedata,
  input  logic        readenable,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  input  logic        uart_received,
  input  logic [7:0]  uart_rx_byte,
  input  logic        uart_recv_error
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TXC_W    = TX_DEPTH_LOG2 + 1;
  localparam int RXC_W    = RX_DEPTH_LOG2 + 1;

  localparam logic [TXC_W-1:0]         TX_FULL_CNT = TXC_W'(TX_DEPTH);
  localparam logic [RXC_W-1:0]         RX_FULL_CNT = RXC_W'(RX_DEPTH);
  localparam logic [TXC_W-1:0]         TX_CNT_ONE  = TXC_W'(1);
  localparam logic [RXC_W-1:0]         RX_CNT_ONE  = RXC_W'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]               r_tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wptr;
  logic [TX_DEPTH_LOG2-1:0] r_tx_rptr;
  logic [TXC_W-1:0]         r_tx_count;

  logic [7:0]               r_rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wptr;
  logic [RX_DEPTH_LOG2-1:0] r_rx_rptr;
  logic [RXC_W-1:0]         r_rx_count;

  logic        r_tx_ovf;
  logic        r_rx_ovr;
  logic        r_rx_ferr;
  logic        r_rx_irq_en;
  logic        r_tx_irq_en;
  logic [31:0] r_readdata;
  logic        r_irq;
  logic        r_uart_transmit;
  logic [7:0]  r_uart_tx_byte;
  state_t      r_state;

  logic        w_ctrl_wr;
  logic        w_stat_rd;
  logic        w_tx_flush;
  logic        w_rx_flush;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_nonempty;
  logic        w_tx_push_req;
  logic        w_tx_push;
  logic        w_tx_launch;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_tx_ovf_set;
  logic        w_rx_ovr_set;
  logic [7:0]  w_tx_head;
  logic [7:0]  w_rx_head;
  logic [31:0] w_status;
  logic [31:0] w_rx_rdata;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^writedata[31:8];

  assign w_ctrl_wr     = writeenable & rw;
  assign w_stat_rd     = readenable & rw;
  assign w_tx_flush    = w_ctrl_wr & writedata[0];
  assign w_rx_flush    = w_ctrl_wr & writedata[1];

  assign w_tx_full     = (r_tx_count == TX_FULL_CNT);
  assign w_tx_empty    = (r_tx_count == '0);
  assign w_rx_full     = (r_rx_count == RX_FULL_CNT);
  assign w_rx_nonempty = (r_rx_count != '0);
  assign w_tx_head     = r_tx_mem[r_tx_rptr];
  assign w_rx_head     = r_rx_mem[r_rx_rptr];

  // A flush wins over any same-cycle launch, so the drain never pops a flushed entry.
  assign w_tx_launch   = (r_state == S_IDLE) & ~w_tx_empty & ~uart_is_transmitting & ~w_tx_flush;
  assign w_tx_pop      = w_tx_launch;
  assign w_tx_push_req = writeenable & ~rw;
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set  = w_tx_push_req & ~w_tx_push;

  assign w_rx_pop      = readenable & ~rw & w_rx_nonempty & ~w_rx_flush;
  assign w_rx_push     = uart_received & ~w_rx_flush & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr_set  = uart_received & ~w_rx_flush & w_rx_full & ~w_rx_pop;

  assign w_rx_rdata    = w_rx_pop ? {23'd0, 1'b1, w_rx_head} : 32'd0;

  always_comb begin
    w_status                = '0;
    w_status[0]             = w_tx_full;
    w_status[1]             = w_tx_empty;
    w_status[2]             = w_rx_nonempty;
    w_status[3]             = r_rx_ovr;
    w_status[4]             = r_rx_ferr;
    w_status[5]             = r_tx_ovf;
    w_status[6]             = r_rx_irq_en;
    w_status[7]             = r_tx_irq_en;
    w_status[8 +: TXC_W]    = r_tx_count;
    w_status[16 +: RXC_W]   = r_rx_count;
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= writedata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else if (w_tx_flush) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + TX_CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - TX_CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else if (w_rx_flush) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + RX_CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - RX_CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_ovf    <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_readdata  <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_tx_ovf  <= w_tx_ovf_set    | (r_tx_ovf  & ~w_stat_rd);
      r_rx_ovr  <= w_rx_ovr_set    | (r_rx_ovr  & ~w_stat_rd);
      r_rx_ferr <= uart_recv_error | (r_rx_ferr & ~w_stat_rd);
      if (w_ctrl_wr) begin
        r_rx_irq_en <= writedata[2];
        r_tx_irq_en <= writedata[3];
      end
      if (readenable) r_readdata <= rw ? w_status : w_rx_rdata;
      r_irq <= (r_rx_irq_en & w_rx_nonempty) |
               (r_tx_irq_en & w_tx_empty & (r_state == S_IDLE));
    end
  end

  // WAIT_BUSY absorbs the core's start latency so busy is never sampled too early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_uart_transmit <= 1'b0;
      r_uart_tx_byte  <= '0;
    end else begin
      r_uart_transmit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tx_launch) begin
            r_uart_transmit <= 1'b1;
            r_uart_tx_byte  <= w_tx_head;
            r_state         <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: if (uart_is_transmitting)  r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!uart_is_transmitting) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign readdata      = r_readdata;
  assign irq           = r_irq;
  assign uart_transmit = r_uart_transmit;
  assign uart_tx_byte  = r_uart_tx_byte;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: stimulus queues expected read data and
// transmitted bytes; a negedge monitor with a simple core model checks them.
module tb_uart_fifo_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rw = 1'b0;
  logic        writeenable = 1'b0;
  logic [31:0] writedata = '0;
  logic        readenable = 1'b0;
  logic [31:0] readdata;
  logic        irq;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting = 1'b0;
  logic        uart_received = 1'b0;
  logic [7:0]  uart_rx_byte = '0;
  logic        uart_recv_error = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;
  int core_cnt = 0;
  int core_hold = 20;
  logic force_busy = 1'b0;
  logic rd_pend = 1'b0;

  logic [31:0] rd_exp [$];
  logic [7:0]  tx_exp [$];

  uart_fifo_bridge #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .rw(rw), .writeenable(writeenable),
    .writedata(writedata), .readenable(readenable), .readdata(readdata),
    .irq(irq), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .uart_received(uart_received),
    .uart_rx_byte(uart_rx_byte), .uart_recv_error(uart_recv_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor and core model: reads complete one cycle after the strobe; a transmit
  // pulse must carry the next expected byte and arrive while the core is idle.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) chk("rd_unexpected", readdata, 32'hDEAD_BEEF);
      else chk("readdata", readdata, rd_exp.pop_front());
    end
    rd_pend = readenable;
    if (uart_transmit) begin
      n_pulses++;
      if (tx_exp.size() == 0) chk("tx_unexpected", {24'd0, uart_tx_byte}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, uart_tx_byte}, {24'd0, tx_exp.pop_front()});
      chk("tx_start_while_busy", {31'd0, uart_is_transmitting}, 32'd0);
      core_cnt = core_hold;
    end else if (core_cnt > 0) begin
      core_cnt--;
    end
    uart_is_transmitting = force_busy | (core_cnt != 0);
  end

  task automatic wr(input logic r, input logic [31:0] d);
    writeenable = 1'b1; rw = r; writedata = d;
    @(posedge clk); #1;
    writeenable = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic r, input logic [31:0] exp);
    readenable = 1'b1; rw = r;
    rd_exp.push_back(exp);
    @(posedge clk); #1;
    readenable = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    uart_received = 1'b1; uart_rx_byte = b;
    @(posedge clk); #1;
    uart_received = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cycles(3);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_transmit", {31'd0, uart_transmit}, 32'd0);
    reset_n = 1'b1;
    cycles(1);
    rd(1'b1, 32'h0000_0002);

    // Three bytes drained through a core busy for 20 cycles each
    n_pulses = 0;
    core_hold = 20;
    tx_exp.push_back(8'h41); tx_exp.push_back(8'h42); tx_exp.push_back(8'h43);
    wr(1'b0, 32'h41); wr(1'b0, 32'h42); wr(1'b0, 32'h43);
    for (int i = 0; i < 400 && (tx_exp.size() != 0 || uart_is_transmitting); i++)
      @(posedge clk);
    #1;
    chk("tx_drain_pending", 32'(tx_exp.size()), 32'd0);
    cycles(3);
    chk("tx_pulse_count", 32'(n_pulses), 32'd3);
    rd(1'b1, 32'h0000_0002);

    // TX overflow with the core held busy
    force_busy = 1'b1;
    cycles(2);
    for (int i = 0; i < 17; i++) wr(1'b0, 32'h80 + 32'(i));
    rd(1'b1, 32'h0000_1021);
    rd(1'b1, 32'h0000_1001);
    wr(1'b1, 32'h1);
    force_busy = 1'b0;
    rd(1'b1, 32'h0000_0002);
    cycles(3);

    // RX overflow then drain
    for (int i = 0; i < 17; i++) rx_pulse(8'(i));
    rd(1'b1, 32'h0010_000E);
    for (int i = 0; i < 16; i++) rd(1'b0, 32'h100 | 32'(i));
    rd(1'b0, 32'h0000_0000);
    rd(1'b1, 32'h0000_0002);

    // Framing error is sticky until a STATUS read
    uart_recv_error = 1'b1;
    cycles(1);
    uart_recv_error = 1'b0;
    rd(1'b1, 32'h0000_0012);
    rd(1'b1, 32'h0000_0002);

    // Full RX FIFO with read and receive in the same cycle
    for (int i = 0; i < 16; i++) rx_pulse(8'h20 + 8'(i));
    readenable = 1'b1; rw = 1'b0; rd_exp.push_back(32'h120);
    uart_received = 1'b1; uart_rx_byte = 8'h30;
    @(posedge clk); #1;
    readenable = 1'b0; uart_received = 1'b0;
    rd(1'b1, 32'h0010_0006);
    for (int i = 1; i < 17; i++) rd(1'b0, 32'h120 + 32'(i));
    rd(1'b1, 32'h0000_0002);

    // Interrupts
    wr(1'b1, 32'h4);
    rd(1'b1, 32'h0000_0042);
    cycles(2);
    chk("irq_rx_empty", {31'd0, irq}, 32'd0);
    rx_pulse(8'h5A);
    cycles(2);
    chk("irq_rx_rise", {31'd0, irq}, 32'd1);
    rd(1'b0, 32'h15A);
    cycles(2);
    chk("irq_rx_fall", {31'd0, irq}, 32'd0);
    wr(1'b1, 32'h8);
    cycles(2);
    chk("irq_tx_idle", {31'd0, irq}, 32'd1);
    wr(1'b1, 32'h0);
    cycles(2);
    chk("irq_tx_off", {31'd0, irq}, 32'd0);

    // Asynchronous reset mid-drain
    rx_pulse(8'h77);
    wr(1'b1, 32'h4);
    tx_exp.push_back(8'h61);
    wr(1'b0, 32'h61); wr(1'b0, 32'h62);
    for (int i = 0; i < 50 && !uart_is_transmitting; i++) @(posedge clk);
    cycles(3);
    rd(1'b1, 32'h0001_0144);
    cycles(1);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk("async_rst_transmit", {31'd0, uart_transmit}, 32'd0);
    chk("async_rst_tx_byte", {24'd0, uart_tx_byte}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 100 && uart_is_transmitting; i++) @(posedge clk);
    cycles(3);
    rd(1'b1, 32'h0000_0002);
    cycles(3);
    chk("tx_exp_left", 32'(tx_exp.size()), 32'd0);
    chk("rd_exp_left", 32'(rd_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Buffered front-end between the CPU data bus and the UART core (the uart instance with transmit/tx_byte/received/rx_byte/is_transmitting/recv_error).
- Queues outbound bytes in a TX FIFO and drains them to the core one at a time. Captures inbound bytes into an RX FIFO.
- Exposes a data register and a status/control register using the same rw-select bus protocol as the existing UART controller, plus an interrupt output.

Parameters:
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries); legal range 1..6.
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries); legal range 1..6.

Ports:
- clk  in  1  system clock; everything on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rw  in  1  register select: 0 = DATA, 1 = STATUS/CTRL.
- writeenable  in  1  bus write strobe, one cycle per access.
- writedata  in  32  bus write data.
- readenable  in  1  bus read strobe, one cycle per access.
- readdata  out  32  registered read data.
- irq  out  1  registered interrupt request.
- uart_transmit  out  1  one-cycle start pulse to the core.
- uart_tx_byte  out  8  byte presented with uart_transmit.
- uart_is_transmitting  in  1  core busy flag.
- uart_received  in  1  core one-cycle byte-received pulse.
- uart_rx_byte  in  8  received byte, valid with uart_received.
- uart_recv_error  in  1  core framing-error pulse.

Behaviour:
- Reset: asynchronous and active-low. Assertion immediately clears:
  - both FIFOs (counts 0, pointers 0) and all sticky flags;
  - the irq enables, and irq itself;
  - readdata = 0, uart_transmit = 0, uart_tx_byte = 0;
  - the FSM, which returns to IDLE.
  - Reset mid-transmission abandons the queue; the core finishes its own frame independently.
- FIFOs:
  - Circular buffers with (DEPTH_LOG2+1)-bit counts; pointers wrap modulo depth.
  - A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- DATA write (writeenable, rw=0): push writedata[7:0] to TX FIFO. If rejected, set sticky tx_ovf.
- CTRL write (writeenable, rw=1):
  - bit0 = flush TX FIFO; bit1 = flush RX FIFO; bit2 = rx_irq_en; bit3 = tx_irq_en.
  - Flush takes priority over a same-cycle push/pop on that FIFO.
  - A TX flush does not abort a byte already handed to the core.
- DATA read (readenable, rw=0):
  - Next cycle, readdata = {23'd0, rx_valid, rx_byte}.
  - If the RX FIFO is non-empty: rx_valid = 1, rx_byte = head, and the entry is popped.
  - If empty: readdata = 0 and nothing is popped.
- STATUS read (readenable, rw=1): next cycle readdata carries
  - bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty;
  - bit3 rx_ovr, bit4 rx_ferr, bit5 tx_ovf;
  - bit6 rx_irq_en, bit7 tx_irq_en;
  - [8 +: TX_DEPTH_LOG2+1] tx_count, [16 +: RX_DEPTH_LOG2+1] rx_count; all other bits 0.
  - The read returns sticky bits 3..5 as they stood before the read, then clears them. A same-cycle set event wins over the clear.
- readdata holds its value when readenable = 0. Read latency is 1 cycle.
- RX capture:
  - uart_received pushes uart_rx_byte. If rejected, the byte is dropped and rx_ovr is set.
  - uart_recv_error sets rx_ferr. The byte, if uart_received is also asserted, is still pushed.
- TX drain FSM:
  - IDLE: if TX FIFO non-empty and uart_is_transmitting = 0, then:
    - assert uart_transmit for exactly 1 cycle with uart_tx_byte = head;
    - pop the head;
    - go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart_is_transmitting = 1, then go to WAIT_DONE. This covers the core's start latency.
  - WAIT_DONE: wait for uart_is_transmitting = 0, then go to IDLE.
  - Minimum gap: one IDLE cycle between consecutive transmit pulses.
  - uart_tx_byte holds the last sent byte while not transmitting.
- irq (registered, updated every cycle) = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty & FSM==IDLE).

Test Plan:
- Reset then STATUS read -> readdata = 0x0000_0002 (tx_empty only); irq = 0, uart_transmit = 0.
- Write 0x41, 0x42, 0x43 to DATA with a core model busy for 20 cycles per byte -> exactly 3 transmit pulses with bytes 0x41, 0x42, 0x43 in order; each pulse is issued only after busy has fallen; then tx_empty = 1.
- Hold core busy, write 17 bytes -> first 16 queued, 17th dropped. STATUS shows tx_full = 1, tx_ovf = 1, tx_count = 16; a second STATUS read shows tx_ovf = 0.
- Inject 17 received pulses with bytes 0x00..0x10 -> rx_count = 16, rx_ovr = 1. Then 16 DATA reads return 0x100..0x10F; a 17th DATA read returns 0x0000_0000.
- RX FIFO full, DATA read and uart_received in the same cycle -> pop succeeds, push accepted, rx_count stays 16, rx_ovr stays 0.
- Enable rx_irq_en, receive byte 0x5A -> irq rises within 2 cycles. DATA read returns 0x15A, then irq falls. Assert reset_n low mid-drain -> all outputs 0 without waiting for a clock edge.
